// File: rtl/elbeth_mem_pkg.sv
// ----------------------------------------------------------------------------
// elbeth_mem_pkg
// Shared types and default constants for the elbeth dual-port memory:
//   port_state_e  per-port request FSM state (IDLE / WAIT / DONE)
//   DEF_*         default parameter values used by the top and port control
//   cnt_width()   width of the per-port latency down-counter
// ----------------------------------------------------------------------------
package elbeth_mem_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DEPTH      = 256;
   localparam int DEF_LATENCY    = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } port_state_e;

   // Counter must hold LATENCY-1; keep at least one bit so LATENCY=1 still works.
   function automatic int cnt_width(input int latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/elbeth_mem_port_ctrl.sv
// ----------------------------------------------------------------------------
// elbeth_mem_port_ctrl
// Request sequencer for one memory port. Latches a request in IDLE, waits
// LATENCY cycles on a down-counter, flags the access cycle to the array, then
// pulses ready (and error for out-of-range addresses) for one cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for en; request fields latched on acceptance
// WAIT    | counting down; access asserted in the cycle the counter is 0
// DONE    | ready/error pulse visible; en ignored; returns to IDLE
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en, addr, wdata,  request strobe and fields (sampled only in IDLE)
//   we
//   access            array access strobe for this cycle (combinational)
//   req_addr/wdata/we latched request fields
//   req_oob           latched address is outside the array
//   ready, error      one-cycle completion pulse and out-of-range flag
// ----------------------------------------------------------------------------
module elbeth_mem_port_ctrl
   import elbeth_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int LATENCY    = DEF_LATENCY
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] we,
   output logic                    access,
   output logic [ADDR_WIDTH-1:0]   req_addr,
   output logic [DATA_WIDTH-1:0]   req_wdata,
   output logic [DATA_WIDTH/8-1:0] req_we,
   output logic                    req_oob,
   output logic                    ready,
   output logic                    error
);

   localparam int                  CW       = cnt_width(LATENCY);
   localparam logic [CW-1:0]       CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

   port_state_e   state;
   logic [CW-1:0] cnt;

   // Extra top bit so DEPTH == 2**ADDR_WIDTH never flags an error.
   assign req_oob = ({1'b0, req_addr} >= DEPTH_W);
   assign access  = (state == ST_WAIT) && (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_we    <= '0;
         ready     <= 1'b0;
         error     <= 1'b0;
      end else begin
         ready <= 1'b0;
         error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en) begin
                  req_addr  <= addr;
                  req_wdata <= wdata;
                  req_we    <= we;
                  cnt       <= CNT_LOAD;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_DONE;
                  ready <= 1'b1;
                  error <= req_oob;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/elbeth_dp_memory.sv
// ----------------------------------------------------------------------------
// elbeth_dp_memory
// Dual-port word memory with byte-lane writes and per-port fixed latency.
// Each port has its own request sequencer; the array, collision priority and
// read-data registers live here.
//
// Ports (X in {a, b}):
//   clk, rst   clock, asynchronous active-high reset
//   X_en       request strobe
//   X_addr     word address
//   X_wdata    write data
//   X_we       byte-lane write mask, all-zero means read
//   X_rdata    read data, held until the next completed read on that port
//   X_ready    one-cycle completion pulse
//   X_error    out-of-range flag, coincident with X_ready
// ----------------------------------------------------------------------------
module elbeth_dp_memory
   import elbeth_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int A_LATENCY  = DEF_LATENCY,
   parameter int B_LATENCY  = DEF_LATENCY
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    a_en,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH-1:0]   a_wdata,
   input  logic [DATA_WIDTH/8-1:0] a_we,
   output logic [DATA_WIDTH-1:0]   a_rdata,
   output logic                    a_ready,
   output logic                    a_error,
   input  logic                    b_en,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   input  logic [DATA_WIDTH-1:0]   b_wdata,
   input  logic [DATA_WIDTH/8-1:0] b_we,
   output logic [DATA_WIDTH-1:0]   b_rdata,
   output logic                    b_ready,
   output logic                    b_error
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                  a_access, b_access;
   logic                  a_oob, b_oob;
   logic [ADDR_WIDTH-1:0] a_req_addr, b_req_addr;
   logic [DATA_WIDTH-1:0] a_req_wdata, b_req_wdata;
   logic [NB-1:0]         a_req_we, b_req_we;
   logic [IW-1:0]         a_idx, b_idx;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   elbeth_mem_port_ctrl #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .LATENCY    (A_LATENCY)
   ) u_port_a (
      .clk       (clk),
      .rst       (rst),
      .en        (a_en),
      .addr      (a_addr),
      .wdata     (a_wdata),
      .we        (a_we),
      .access    (a_access),
      .req_addr  (a_req_addr),
      .req_wdata (a_req_wdata),
      .req_we    (a_req_we),
      .req_oob   (a_oob),
      .ready     (a_ready),
      .error     (a_error)
   );

   elbeth_mem_port_ctrl #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .LATENCY    (B_LATENCY)
   ) u_port_b (
      .clk       (clk),
      .rst       (rst),
      .en        (b_en),
      .addr      (b_addr),
      .wdata     (b_wdata),
      .we        (b_we),
      .access    (b_access),
      .req_addr  (b_req_addr),
      .req_wdata (b_req_wdata),
      .req_we    (b_req_we),
      .req_oob   (b_oob),
      .ready     (b_ready),
      .error     (b_error)
   );

   // Truncation is safe: the index is only used when the address is in range.
   assign a_idx = a_req_addr[IW-1:0];
   assign b_idx = b_req_addr[IW-1:0];

   // No reset on the array so contents survive rst. Port B lanes are written
   // first so port A's later assignment wins on overlapping lanes.
   always_ff @(posedge clk) begin
      if (b_access && !b_oob) begin
         for (int i = 0; i < NB; i++) begin
            if (b_req_we[i]) mem[b_idx][i*8 +: 8] <= b_req_wdata[i*8 +: 8];
         end
      end
      if (a_access && !a_oob) begin
         for (int i = 0; i < NB; i++) begin
            if (a_req_we[i]) mem[a_idx][i*8 +: 8] <= a_req_wdata[i*8 +: 8];
         end
      end
   end

   // Reads sample the array before same-cycle writes land (read-before-write).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         if (a_access) begin
            if (a_oob)              a_rdata <= '0;
            else if (a_req_we == '0) a_rdata <= mem[a_idx];
         end
         if (b_access) begin
            if (b_oob)              b_rdata <= '0;
            else if (b_req_we == '0) b_rdata <= mem[b_idx];
         end
      end
   end

endmodule

// File: tb/tb_elbeth_dp_memory.sv
module tb_elbeth_dp_memory;

   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 200;
   localparam int A_LAT = 3;
   localparam int B_LAT = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_en = 1'b0, b_en = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic [3:0]    a_we = '0, b_we = '0;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          a_ready, a_error, b_ready, b_error;

   always #5 clk = ~clk;

   elbeth_dp_memory #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .A_LATENCY  (A_LAT),
      .B_LATENCY  (B_LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .a_en    (a_en),
      .a_addr  (a_addr),
      .a_wdata (a_wdata),
      .a_we    (a_we),
      .a_rdata (a_rdata),
      .a_ready (a_ready),
      .a_error (a_error),
      .b_en    (b_en),
      .b_addr  (b_addr),
      .b_wdata (b_wdata),
      .b_we    (b_we),
      .b_rdata (b_rdata),
      .b_ready (b_ready),
      .b_error (b_error)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Behavioural model: each port is busy for LAT+2 edges after acceptance and
   // completes its access LAT edges after the accepting edge.
   logic [31:0] m_mem   [256];
   logic [3:0]  m_known [256];
   int          lat       [2] = '{A_LAT, B_LAT};
   int          next_free [2];
   bit          pend      [2];
   int          acc_cyc   [2];
   logic [7:0]  p_addr    [2];
   logic [31:0] p_wd      [2];
   logic [3:0]  p_we      [2];
   bit          exp_rdy   [2];
   bit          exp_err   [2];
   logic [31:0] exp_rd    [2];
   bit          exp_known [2];

   // Observed DUT completions.
   int          a_rdy_cnt = 0, b_rdy_cnt = 0;
   int          a_last_cyc = 0, b_last_cyc = 0;
   logic [31:0] a_last_rd = '0, b_last_rd = '0;
   logic        a_last_err = 1'b0, b_last_err = 1'b0;
   int          b_cycs [$];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit          en_v [2];
      logic [7:0]  ad_v [2];
      logic [31:0] wd_v [2];
      logic [3:0]  we_v [2];
      en_v[0] = a_en; ad_v[0] = a_addr; wd_v[0] = a_wdata; we_v[0] = a_we;
      en_v[1] = b_en; ad_v[1] = b_addr; wd_v[1] = b_wdata; we_v[1] = b_we;
      cyc++;
      if (rst) begin
         for (int p = 0; p < 2; p++) begin
            pend[p] = 0; next_free[p] = cyc + 1;
            exp_rdy[p] = 0; exp_err[p] = 0; exp_rd[p] = '0; exp_known[p] = 1;
         end
         return;
      end
      for (int p = 0; p < 2; p++) begin
         exp_rdy[p] = 0; exp_err[p] = 0;
         if (pend[p] && acc_cyc[p] == cyc) begin
            exp_rdy[p] = 1;
            if (p_addr[p] >= DEPTH) begin
               exp_err[p] = 1; exp_rd[p] = '0; exp_known[p] = 1;
            end else if (p_we[p] == 4'h0) begin
               exp_rd[p]    = m_mem[p_addr[p]];
               exp_known[p] = (m_known[p_addr[p]] == 4'hF);
            end
         end
      end
      for (int p = 1; p >= 0; p--) begin
         if (pend[p] && acc_cyc[p] == cyc && p_addr[p] < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
               if (p_we[p][i]) begin
                  m_mem[p_addr[p]][i*8 +: 8] = p_wd[p][i*8 +: 8];
                  m_known[p_addr[p]][i]      = 1'b1;
               end
            end
         end
      end
      for (int p = 0; p < 2; p++) begin
         if (pend[p] && acc_cyc[p] == cyc) pend[p] = 0;
         if (en_v[p] && !pend[p] && cyc >= next_free[p]) begin
            pend[p]      = 1;
            acc_cyc[p]   = cyc + lat[p];
            next_free[p] = cyc + lat[p] + 2;
            p_addr[p] = ad_v[p]; p_wd[p] = wd_v[p]; p_we[p] = we_v[p];
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         m_known[i] = 4'h0;
         m_mem[i]   = '0;
      end
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check32("a_ready", {31'd0, a_ready}, {31'd0, exp_rdy[0]});
         check32("a_error", {31'd0, a_error}, {31'd0, exp_err[0]});
         check32("b_ready", {31'd0, b_ready}, {31'd0, exp_rdy[1]});
         check32("b_error", {31'd0, b_error}, {31'd0, exp_err[1]});
         if (exp_known[0]) check32("a_rdata", a_rdata, exp_rd[0]);
         if (exp_known[1]) check32("b_rdata", b_rdata, exp_rd[1]);
         if (a_ready) begin
            a_rdy_cnt++; a_last_cyc = cyc; a_last_rd = a_rdata; a_last_err = a_error;
         end
         if (b_ready) begin
            b_rdy_cnt++; b_last_cyc = cyc; b_last_rd = b_rdata; b_last_err = b_error;
            b_cycs.push_back(cyc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_a(input logic [7:0] ad, input logic [31:0] wd, input logic [3:0] we);
      a_en = 1'b1; a_addr = ad; a_wdata = wd; a_we = we;
   endtask

   task automatic set_b(input logic [7:0] ad, input logic [31:0] wd, input logic [3:0] we);
      b_en = 1'b1; b_addr = ad; b_wdata = wd; b_we = we;
   endtask

   task automatic a_txn(input logic [7:0] ad, input logic [31:0] wd, input logic [3:0] we);
      int c0;
      c0 = a_rdy_cnt;
      step(1); set_a(ad, wd, we);
      step(1); a_en = 1'b0;
      step(A_LAT + 2);
      check32("a_txn ready count", a_rdy_cnt - c0, 1);
   endtask

   task automatic b_txn(input logic [7:0] ad, input logic [31:0] wd, input logic [3:0] we);
      int c0;
      c0 = b_rdy_cnt;
      step(1); set_b(ad, wd, we);
      step(1); b_en = 1'b0;
      step(B_LAT + 2);
      check32("b_txn ready count", b_rdy_cnt - c0, 1);
   endtask

   // A accepted at edge N, B at edge N+2: both access at edge N+3.
   task automatic aligned(input logic [7:0] aa, input logic [31:0] aw, input logic [3:0] ae,
                          input logic [7:0] ba, input logic [31:0] bw, input logic [3:0] be);
      step(1); set_a(aa, aw, ae);
      step(1); a_en = 1'b0;
      step(1); set_b(ba, bw, be);
      step(1); b_en = 1'b0;
      step(4);
   endtask

   initial begin
      int t_req, c0, q0;
      repeat (3) @(negedge clk);
      check32("reset a_rdata", a_rdata, 32'h0);
      check32("reset b_rdata", b_rdata, 32'h0);
      check32("reset readies", {30'd0, a_ready, b_ready}, 32'h0);

      // First edge after reset release accepts a request.
      #1; rst = 1'b0; set_b(8'h30, 32'h12345678, 4'hF); t_req = cyc + 1;
      step(1); b_en = 1'b0;
      step(3);
      check32("first-edge accept count", b_rdy_cnt, 1);
      check32("first-edge accept latency", b_last_cyc - t_req, B_LAT);

      a_txn(8'h10, 32'h5A5A5A5A, 4'hF);
      b_txn(8'h20, 32'h00000000, 4'hF);
      b_txn(8'hC7, 32'h0BADF00D, 4'hF);

      // Reset in the middle of a port A write wait.
      c0 = a_rdy_cnt;
      step(1); set_a(8'h10, 32'hDEADBEEF, 4'hF);
      step(1); a_en = 1'b0;
      step(1); rst = 1'b1;
      step(2); rst = 1'b0;
      step(6);
      check32("reset drop no ready", a_rdy_cnt - c0, 0);
      a_txn(8'h10, 32'h0, 4'h0);
      check32("reset drop read 0x10", a_last_rd, 32'h5A5A5A5A);

      // Byte lanes.
      a_txn(8'h04, 32'hAABBCCDD, 4'hF);
      a_txn(8'h04, 32'h11223344, 4'b0101);
      a_txn(8'h04, 32'h0, 4'h0);
      check32("byte lane read 0x04", a_last_rd, 32'hAA22CC44);

      // Same-cycle writes to 0x20 (stored zero).
      aligned(8'h20, 32'h11111111, 4'b0011, 8'h20, 32'h22222222, 4'b0110);
      b_txn(8'h20, 32'h0, 4'h0);
      check32("collision read 0x20", b_last_rd, 32'h00221111);

      // Same-cycle A write / B read returns old data.
      aligned(8'h30, 32'hCAFEBABE, 4'hF, 8'h30, 32'h0, 4'h0);
      check32("read-before-write", b_last_rd, 32'h12345678);
      b_txn(8'h30, 32'h0, 4'h0);
      check32("read after write", b_last_rd, 32'hCAFEBABE);

      // Two same-cycle reads of one word.
      aligned(8'h04, 32'h0, 4'h0, 8'h04, 32'h0, 4'h0);
      check32("dual read a", a_last_rd, 32'hAA22CC44);
      check32("dual read b", b_last_rd, 32'hAA22CC44);

      // Simultaneous reads, differing latency.
      step(1); set_a(8'h10, 32'h0, 4'h0); set_b(8'h30, 32'h0, 4'h0); t_req = cyc + 1;
      step(1); a_en = 1'b0; b_en = 1'b0;
      step(5);
      check32("b latency edges", b_last_cyc - t_req + 1, 2);
      check32("a latency edges", a_last_cyc - t_req + 1, 4);
      check32("latency a data", a_last_rd, 32'h5A5A5A5A);
      check32("latency b data", b_last_rd, 32'hCAFEBABE);

      // Out-of-range boundary.
      b_txn(8'hC8, 32'h0, 4'h0);
      check32("oob error", {31'd0, b_last_err}, 32'h1);
      check32("oob rdata", b_last_rd, 32'h0);
      b_txn(8'hC7, 32'h0, 4'h0);
      check32("last word no error", {31'd0, b_last_err}, 32'h0);
      check32("last word rdata", b_last_rd, 32'h0BADF00D);

      // en held for 10 edges on a latency-1 port.
      c0 = b_rdy_cnt; q0 = b_cycs.size();
      step(1); set_b(8'h04, 32'h0, 4'h0);
      step(10);
      check32("busy completions in window", b_rdy_cnt - c0, 3);
      b_en = 1'b0;
      check32("busy spacing 1", b_cycs[q0+1] - b_cycs[q0], 3);
      check32("busy spacing 2", b_cycs[q0+2] - b_cycs[q0+1], 3);
      step(4);
      check32("busy trailing completion", b_rdy_cnt - c0, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
